// File: rtl/mpmc11_pkg.sv
// Shared types for the mpmc11 LR/SC reservation table.
package mpmc11_pkg;

   // Request opcode as presented by the controller's arbiter.
   typedef enum logic [1:0] {
      READ  = 2'b00,
      LR    = 2'b01,
      WRITE = 2'b10,
      SC    = 2'b11
   } resv_op_t;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

endpackage

// File: rtl/mpmc11_resv_entry.sv
// One reservation entry: owner channel, granule tag and age counter.
// Allocation is decided by the parent; this entry only reports its matches
// and applies set / invalidate / expiry to itself.
module mpmc11_resv_entry
   import mpmc11_pkg::*;
#(
   parameter int CHW     = 3,
   parameter int TW      = 27,
   parameter int TIMEOUT = 16,
   parameter int AGW     = 5
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clr,      // flush everything, beats every other update
   input  logic           alloc,    // LR chosen this entry
   input  logic           is_wr,    // valid WRITE this cycle
   input  logic           is_sc,    // valid SC this cycle
   input  logic           sc_hit,   // table-wide SC success this cycle
   input  logic [CHW-1:0] req_ch,
   input  logic [TW-1:0]  req_tag,
   output logic           valid,
   output logic           own,      // valid and owned by the requesting channel
   output logic           hit       // valid, owned by requester and same tag
);

   typedef struct packed {
      logic           valid;
      logic [CHW-1:0] ch;
      logic [TW-1:0]  tag;
      logic [AGW-1:0] age;
   } entry_t;

   // Last age value before expiry; unused when ageing is disabled.
   localparam logic [AGW-1:0] AGE_LAST = (TIMEOUT > 0) ? AGW'(TIMEOUT - 1) : '0;

   entry_t q, d;
   logic   tag_m;
   logic   inv;
   logic   expire;

   assign valid = q.valid;
   assign own   = q.valid && (q.ch == req_ch);
   assign tag_m = q.valid && (q.tag == req_tag);
   assign hit   = own && tag_m;

   // A write kills other channels' reservations on the granule; an SC kills
   // the whole granule on success, otherwise only the caller's own entry.
   assign inv    = (is_wr && tag_m && !own) ||
                   (is_sc && (sc_hit ? tag_m : own));
   assign expire = (TIMEOUT > 0) && q.valid && (q.age == AGE_LAST);

   // Next-state: flush, then LR set, then request invalidation / expiry, else age.
   always_comb begin
      d = q;
      if (clr) begin
         d.valid = FALSE;
         d.age   = '0;
      end else if (alloc) begin
         d.valid = TRUE;
         d.ch    = req_ch;
         d.tag   = req_tag;
         d.age   = '0;
      end else if (inv || expire) begin
         d.valid = FALSE;
         d.age   = '0;
      end else if (q.valid && (TIMEOUT > 0)) begin
         d.age = q.age + 1'b1;
      end
   end

   // Entry register.
   always_ff @(posedge clk) begin
      if (rst) q <= '0;
      else     q <= d;
   end

endmodule

// File: rtl/mpmc11_resv_table.sv
// LR/SC reservation table: NAR entries shared by NCH channels. Chooses the
// entry an LR lands in, computes the SC verdict and registers it for the
// following cycle.
module mpmc11_resv_table
   import mpmc11_pkg::*;
#(
   parameter int NCH     = 8,
   parameter int NAR     = 4,
   parameter int AW      = 32,
   parameter int GRAN    = 5,
   parameter int TIMEOUT = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_v,
   input  logic [$clog2(NCH)-1:0]  req_ch,
   input  logic [1:0]              req_op,
   input  logic [AW-1:0]           req_adr,
   input  logic                    clr_all,
   output logic                    sc_done,
   output logic                    sc_ok,
   output logic [NAR-1:0]          resv_v
);

   localparam int CHW = $clog2(NCH);
   localparam int TW  = AW - GRAN;
   localparam int AGW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int RRW = (NAR > 1) ? $clog2(NAR) : 1;

   logic [TW-1:0]  req_tag;
   logic           is_lr, is_wr, is_sc;
   logic           sc_hit;
   logic [NAR-1:0] own_vec, hit_vec, alloc_vec;
   logic [RRW-1:0] rr;
   logic [RRW-1:0] sel;
   logic           found;
   logic           rr_adv;

   // Bytes within a granule never distinguish reservations.
   assign req_tag = req_adr[AW-1:GRAN];

   // A flush drops a concurrent LR; WRITE/SC are harmless under a flush.
   assign is_lr  = req_v && (req_op == LR) && !clr_all;
   assign is_wr  = req_v && (req_op == WRITE);
   assign is_sc  = req_v && (req_op == SC);
   assign sc_hit = |hit_vec;

   // LR placement: caller's own entry, else lowest free entry, else replace rr.
   always_comb begin
      sel       = '0;
      found     = FALSE;
      rr_adv    = FALSE;
      alloc_vec = '0;
      for (int i = 0; i < NAR; i++) begin
         if (!found && own_vec[i]) begin
            sel   = RRW'(i);
            found = TRUE;
         end
      end
      for (int i = 0; i < NAR; i++) begin
         if (!found && !resv_v[i]) begin
            sel   = RRW'(i);
            found = TRUE;
         end
      end
      if (!found) begin
         sel    = rr;
         rr_adv = is_lr;
      end
      if (is_lr) alloc_vec[sel] = TRUE;
   end

   // Replacement pointer moves only when an LR had to evict.
   always_ff @(posedge clk) begin
      if (rst)         rr <= '0;
      else if (rr_adv) rr <= (rr == RRW'(NAR - 1)) ? '0 : rr + 1'b1;
   end

   // SC verdict, presented the cycle after the SC request.
   always_ff @(posedge clk) begin
      if (rst) begin
         sc_done <= FALSE;
         sc_ok   <= FALSE;
      end else begin
         sc_done <= is_sc;
         sc_ok   <= is_sc && sc_hit && !clr_all;
      end
   end

   for (genvar g = 0; g < NAR; g++) begin : g_entry
      mpmc11_resv_entry #(
         .CHW     (CHW),
         .TW      (TW),
         .TIMEOUT (TIMEOUT),
         .AGW     (AGW)
      ) u_entry (
         .clk     (clk),
         .rst     (rst),
         .clr     (clr_all),
         .alloc   (alloc_vec[g]),
         .is_wr   (is_wr),
         .is_sc   (is_sc),
         .sc_hit  (sc_hit),
         .req_ch  (req_ch),
         .req_tag (req_tag),
         .valid   (resv_v[g]),
         .own     (own_vec[g]),
         .hit     (hit_vec[g])
      );
   end

endmodule

// File: tb/tb_mpmc11_resv_table.sv
// Bench for mpmc11_resv_table: directed scenarios plus random traffic, all
// checked against a reference model that tracks each reservation by the
// cycle its LR was issued.
module tb_mpmc11_resv_table;
   import mpmc11_pkg::*;

   localparam int NCH     = 8;
   localparam int NAR     = 4;
   localparam int AW      = 32;
   localparam int GRAN    = 5;
   localparam int TIMEOUT = 16;
   localparam int W       = NAR + 2;

   // ---------------- clock / reset ----------------
   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           req_v = 1'b0;
   logic [2:0]     req_ch = '0;
   logic [1:0]     req_op = '0;
   logic [AW-1:0]  req_adr = '0;
   logic           clr_all = 1'b0;
   logic           sc_done;
   logic           sc_ok;
   logic [NAR-1:0] resv_v;

   always #5 clk = ~clk;

   mpmc11_resv_table #(
      .NCH(NCH), .NAR(NAR), .AW(AW), .GRAN(GRAN), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req_v   (req_v),
      .req_ch  (req_ch),
      .req_op  (req_op),
      .req_adr (req_adr),
      .clr_all (clr_all),
      .sc_done (sc_done),
      .sc_ok   (sc_ok),
      .resv_v  (resv_v)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // A reservation is alive in cycle k iff k - born <= TIMEOUT.
   bit m_valid[NAR];
   int m_ch[NAR];
   int m_tag[NAR];
   int m_born[NAR];
   int m_rr  = 0;
   int cyc   = 0;

   function automatic bit alive(int i, int k);
      return m_valid[i] && (TIMEOUT == 0 || (k - m_born[i]) <= TIMEOUT);
   endfunction

   task automatic model(input bit r, input bit v, input int ch, input int op,
                        input logic [31:0] adr, input bit clr);
      int  t;
      int  sel;
      bit  ed, eo, hit;
      logic [NAR-1:0] ev;
      t  = int'(adr >> GRAN);
      ed = 1'b0;
      eo = 1'b0;
      if (r) begin
         for (int i = 0; i < NAR; i++) m_valid[i] = 1'b0;
         m_rr = 0;
      end else begin
         for (int i = 0; i < NAR; i++) m_valid[i] = alive(i, cyc);
         ed = v && (op == 3);
         if (clr) begin
            for (int i = 0; i < NAR; i++) m_valid[i] = 1'b0;
         end else if (v) begin
            case (op)
               1: begin
                  sel = -1;
                  for (int i = 0; i < NAR; i++)
                     if (sel < 0 && m_valid[i] && m_ch[i] == ch) sel = i;
                  for (int i = 0; i < NAR; i++)
                     if (sel < 0 && !m_valid[i]) sel = i;
                  if (sel < 0) begin
                     sel  = m_rr;
                     m_rr = (m_rr + 1) % NAR;
                  end
                  m_valid[sel] = 1'b1;
                  m_ch[sel]    = ch;
                  m_tag[sel]   = t;
                  m_born[sel]  = cyc;
               end
               2: begin
                  for (int i = 0; i < NAR; i++)
                     if (m_valid[i] && m_tag[i] == t && m_ch[i] != ch) m_valid[i] = 1'b0;
               end
               3: begin
                  hit = 1'b0;
                  for (int i = 0; i < NAR; i++)
                     if (m_valid[i] && m_tag[i] == t && m_ch[i] == ch) hit = 1'b1;
                  eo = hit;
                  for (int i = 0; i < NAR; i++) begin
                     if (hit && m_valid[i] && m_tag[i] == t) m_valid[i] = 1'b0;
                     if (!hit && m_valid[i] && m_ch[i] == ch) m_valid[i] = 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
      for (int i = 0; i < NAR; i++) ev[i] = alive(i, cyc + 1);
      exp_q.push_back({ed, eo, ev});
      cyc++;
   endtask

   // ---------------- driver ----------------
   task automatic step(input bit r, input bit v, input int ch, input int op,
                       input logic [31:0] adr, input bit clr);
      logic [W-1:0] e;
      @(negedge clk);
      rst     = r;
      req_v   = v;
      req_ch  = ch[2:0];
      req_op  = op[1:0];
      req_adr = adr;
      clr_all = clr;
      model(r, v, ch, op, adr, clr);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("sc_done", 32'(sc_done), 32'(e[W-1]));
      check("sc_ok",   32'(sc_ok),   32'(e[W-2]));
      check("resv_v",  32'(resv_v),  32'(e[NAR-1:0]));
   endtask

   task automatic do_reset();
      step(1, 0, 0, 0, 0, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      do_reset();
      do_reset();
      check("rst_resv_v",  32'(resv_v),  32'h0);
      check("rst_sc_done", 32'(sc_done), 32'h0);

      // basic LR/SC and consumption
      step(0, 1, 1, 1, 32'h1000, 0);
      step(0, 1, 1, 3, 32'h101C, 0);
      check("p1_ok", 32'(sc_ok), 32'h1);
      step(0, 1, 1, 3, 32'h1000, 0);
      check("p1_consumed", 32'(sc_ok), 32'h0);

      // conflicting write from another channel vs own write
      do_reset();
      step(0, 1, 1, 1, 32'h1000, 0);
      step(0, 1, 2, 2, 32'h1010, 0);
      step(0, 1, 1, 3, 32'h1000, 0);
      check("p2_other_wr", 32'(sc_ok), 32'h0);
      step(0, 1, 1, 1, 32'h1000, 0);
      step(0, 1, 1, 2, 32'h1010, 0);
      step(0, 1, 1, 3, 32'h1000, 0);
      check("p2_own_wr", 32'(sc_ok), 32'h1);

      // eviction by round-robin
      do_reset();
      for (int c = 0; c < 5; c++) step(0, 1, c, 1, 32'(c * 32), 0);
      check("p3_full", 32'(resv_v), 32'hF);
      step(0, 1, 0, 3, 32'h0, 0);
      check("p3_evicted", 32'(sc_ok), 32'h0);
      step(0, 1, 1, 3, 32'h20, 0);
      check("p3_kept", 32'(sc_ok), 32'h1);

      // ageing boundary
      do_reset();
      step(0, 1, 2, 1, 32'h2000, 0);
      idle(TIMEOUT - 1);
      step(0, 1, 2, 3, 32'h2000, 0);
      check("p4_n16", 32'(sc_ok), 32'h1);
      do_reset();
      step(0, 1, 2, 1, 32'h2000, 0);
      idle(TIMEOUT - 1);
      check("p4_live15", 32'(resv_v), 32'h1);
      idle(1);
      check("p4_expired", 32'(resv_v), 32'h0);
      step(0, 1, 2, 3, 32'h2000, 0);
      check("p4_n17", 32'(sc_ok), 32'h0);

      // overwrite in place
      do_reset();
      step(0, 1, 1, 1, 32'h1000, 0);
      step(0, 1, 1, 1, 32'h3000, 0);
      check("p5_one", 32'($countones(resv_v)), 32'h1);
      step(0, 1, 1, 3, 32'h1000, 0);
      check("p5_old", 32'(sc_ok), 32'h0);

      // flush with concurrent SC, then reset mid-flight
      do_reset();
      step(0, 1, 3, 1, 32'h400, 0);
      step(0, 1, 3, 3, 32'h400, 1);
      check("p6_clr_done", 32'(sc_done), 32'h1);
      check("p6_clr_ok",   32'(sc_ok),   32'h0);
      check("p6_clr_v",    32'(resv_v),  32'h0);
      step(0, 1, 3, 1, 32'h400, 0);
      step(0, 1, 3, 3, 32'h400, 0);
      step(1, 1, 3, 3, 32'h400, 0);
      check("p6_rst_v",    32'(resv_v),  32'h0);
      check("p6_rst_done", 32'(sc_done), 32'h0);
      step(0, 1, 3, 3, 32'h400, 0);
      check("p6_after_rst", 32'(sc_ok), 32'h0);

      // random traffic on a handful of granules
      for (int n = 0; n < 1500; n++) begin
         if (n % 300 == 299) idle($urandom_range(10, 20));
         step($urandom_range(0, 199) == 0,
              $urandom_range(0, 3) != 0,
              $urandom_range(0, NCH - 1),
              $urandom_range(0, 3),
              32'h4000 | (32'($urandom_range(0, 4)) << GRAN) | 32'($urandom_range(0, 31)),
              $urandom_range(0, 99) == 0);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
